// File: rtl/tb_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_pkg : shared state encoding and width helpers for the          |
// |              bench phase sequencer                                    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package tb_seq_pkg;

  localparam int c_st_w = 2;

  typedef enum logic [c_st_w-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_e;

  // Index width wide enough to hold the count n itself, not just n-1.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tb_phase_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_phase_sequencer_if : control/status bundle between a bench and     |
// |                         the phase sequencer                           |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
interface tb_phase_sequencer_if
  import tb_seq_pkg::*;
#(
  parameter int CTR_W      = 32,
  parameter int NUM_PHASES = 2,
  parameter int ROUNDS     = 2
) ();

  localparam int c_pw = idx_w(NUM_PHASES);
  localparam int c_rw = idx_w(ROUNDS);

  logic                        start;
  logic                        abort;
  logic [NUM_PHASES*CTR_W-1:0] thr;
  logic [CTR_W-1:0]            ctr;
  logic [c_pw-1:0]             phase_idx;
  logic [c_rw-1:0]             round;
  logic                        event_valid;
  logic [c_pw-1:0]             event_id;
  logic                        busy;
  logic                        done;
  logic                        err;

  modport master (
    output start, abort, thr,
    input  ctr, phase_idx, round, event_valid, event_id, busy, done, err
  );

  modport slave (
    input  start, abort, thr,
    output ctr, phase_idx, round, event_valid, event_id, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/tb_seq_cfg_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_cfg_check : combinational check that thresholds are strictly   |
// |                    increasing                                         |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_seq_cfg_check
  import tb_seq_pkg::*;
#(
  parameter int CTR_W      = 32,
  parameter int NUM_PHASES = 2
) (
  input  logic [NUM_PHASES*CTR_W-1:0] thr,
  output logic                        cfg_ok
);

  generate
    if (NUM_PHASES > 1) begin : g_multi
      logic [NUM_PHASES-2:0] w_gt;

      for (genvar gi = 1; gi < NUM_PHASES; gi++) begin : g_pair
        assign w_gt[gi-1] = thr[gi*CTR_W +: CTR_W] > thr[(gi-1)*CTR_W +: CTR_W];
      end

      assign cfg_ok = &w_gt;
    end else begin : g_single
      // A single threshold has no ordering to violate.
      logic w_unused;
      assign w_unused = ^thr;
      assign cfg_ok   = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tb_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_phase_sequencer : cycle-driven checkpoint scheduler; fires one     |
// |                      event per threshold, counts rounds, flags done   |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_phase_sequencer
  import tb_seq_pkg::*;
#(
  parameter int CTR_W      = 32,
  parameter int NUM_PHASES = 2,
  parameter int ROUNDS     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tb_phase_sequencer_if.slave  bus
);

  localparam int c_pw    = idx_w(NUM_PHASES);
  localparam int c_rw    = idx_w(ROUNDS);
  localparam int c_thr_w = NUM_PHASES * CTR_W;

  localparam logic [c_pw-1:0]  c_last_phase = c_pw'(NUM_PHASES - 1);
  localparam logic [c_pw-1:0]  c_ph_one     = c_pw'(1);
  localparam logic [c_rw-1:0]  c_rounds     = c_rw'(ROUNDS);
  localparam logic [c_rw-1:0]  c_rd_one     = c_rw'(1);
  localparam logic [CTR_W-1:0] c_ctr_one    = CTR_W'(1);

  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [c_thr_w-1:0] r_thr_l;
  logic [c_thr_w-1:0] w_thr_nxt;
  logic [CTR_W-1:0]   r_ctr;
  logic [CTR_W-1:0]   w_ctr_nxt;
  logic [c_pw-1:0]    r_phase;
  logic [c_pw-1:0]    w_phase_nxt;
  logic [c_rw-1:0]    r_round;
  logic [c_rw-1:0]    w_round_nxt;
  logic [c_rw-1:0]    w_round_inc;
  logic               r_ev;
  logic               w_ev_nxt;
  logic [c_pw-1:0]    r_evid;
  logic [c_pw-1:0]    w_evid_nxt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [CTR_W-1:0]   w_cur_thr;
  logic               w_cfg_ok;

  tb_seq_cfg_check #(
    .CTR_W      (CTR_W),
    .NUM_PHASES (NUM_PHASES)
  ) u_cfg_check (
    .thr    (bus.thr),
    .cfg_ok (w_cfg_ok)
  );

  // Threshold of the phase currently awaited, taken from the latched copy.
  always_comb begin
    w_cur_thr = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (r_phase == c_pw'(i)) begin
        w_cur_thr = r_thr_l[i*CTR_W +: CTR_W];
      end
    end
  end

  assign w_round_inc = r_round + c_rd_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_thr_l <= '0;
      r_ctr   <= '0;
      r_phase <= '0;
      r_round <= '0;
      r_ev    <= 1'b0;
      r_evid  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_thr_l <= w_thr_nxt;
      r_ctr   <= w_ctr_nxt;
      r_phase <= w_phase_nxt;
      r_round <= w_round_nxt;
      r_ev    <= w_ev_nxt;
      r_evid  <= w_evid_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_err   <= (w_state_nxt == ST_ERR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_thr_nxt   = r_thr_l;
    w_ctr_nxt   = r_ctr;
    w_phase_nxt = r_phase;
    w_round_nxt = r_round;
    w_ev_nxt    = 1'b0;
    w_evid_nxt  = '0;

    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_ctr_nxt   = '0;
      w_phase_nxt = '0;
      w_round_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            // The live bus value is both checked and captured on this edge.
            w_thr_nxt   = bus.thr;
            w_ctr_nxt   = '0;
            w_phase_nxt = '0;
            w_round_nxt = '0;
            w_state_nxt = w_cfg_ok ? ST_RUN : ST_ERR;
          end
        end

        ST_RUN: begin
          if (r_ctr == w_cur_thr) begin
            w_ev_nxt   = 1'b1;
            w_evid_nxt = r_phase;
            if (r_phase != c_last_phase) begin
              w_phase_nxt = r_phase + c_ph_one;
              w_ctr_nxt   = r_ctr + c_ctr_one;
            end else begin
              w_ctr_nxt   = '0;
              w_phase_nxt = '0;
              w_round_nxt = w_round_inc;
              if (w_round_inc == c_rounds) begin
                w_state_nxt = ST_DONE;
              end
            end
          end else begin
            w_ctr_nxt = r_ctr + c_ctr_one;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ctr         = r_ctr;
  assign bus.phase_idx   = r_phase;
  assign bus.round       = r_round;
  assign bus.event_valid = r_ev;
  assign bus.event_id    = r_evid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule
`default_nettype wire
